cv32e40p_obi_instr_responder: RTL

- OBI instruction-side responder: the memory end of the core's fetch interface (instr_req/gnt/rvalid/rdata/err).
- Accepts fetch requests and grants them. Returns word data in order after a programmable latency, from an internal word array.
- Used as the instruction memory in core-level benches and FPGA bring-up. Stall inputs let the bench exercise prefetcher backpressure.

---
 rtl/cv32e40p_obi_instr_responder.sv | 106 ++++++++++
 1 files changed

// File: rtl/cv32e40p_obi_instr_responder.sv
// OBI instruction-side memory responder: grants fetches, returns array words in order
// after a fixed latency, with stall hooks for exercising prefetcher backpressure.
module cv32e40p_obi_instr_responder #(
  parameter int unsigned MEM_ADDR_WIDTH  = 10,
  parameter logic [31:0] MEM_BASE        = 32'h0000_0000,
  parameter int unsigned RD_LATENCY      = 1,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      instr_req_i,
  input  logic [31:0]               instr_addr_i,
  output logic                      instr_gnt_o,
  output logic                      instr_rvalid_o,
  output logic [31:0]               instr_rdata_o,
  output logic                      instr_err_o,
  input  logic                      gnt_stall_i,
  input  logic                      rvalid_stall_i,
  input  logic                      load_we_i,
  input  logic [MEM_ADDR_WIDTH-1:0] load_addr_i,
  input  logic [31:0]               load_wdata_i,
  output logic [3:0]                outstanding_o,
  output logic                      busy_o
);

  localparam int unsigned   Depth    = 2 ** MEM_ADDR_WIDTH;
  localparam int unsigned   PtrW     = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [32:0]   MemBytes = 33'(Depth) << 2;
  localparam logic [3:0]    WaitInit = 4'(RD_LATENCY - 1);
  localparam logic [3:0]    MaxOut   = 4'(MAX_OUTSTANDING);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(MAX_OUTSTANDING - 1);

  logic [31:0] mem_q [Depth];

  logic [31:0] data_q [MAX_OUTSTANDING];
  logic        err_q  [MAX_OUTSTANDING];
  logic [3:0]  wait_q [MAX_OUTSTANDING];
  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [3:0]  count_q, count_d;

  logic [31:0] off;
  logic        in_range;
  logic [MEM_ADDR_WIDTH-1:0] word_idx;
  logic [31:0] fetch_data;
  logic        push, pop, head_ready;

  // Offset wraps at 32 bits so addresses below MEM_BASE land far out of range.
  assign off        = instr_addr_i - MEM_BASE;
  assign in_range   = ({1'b0, off} < MemBytes);
  assign word_idx   = off[MEM_ADDR_WIDTH+1:2];
  assign fetch_data = in_range ? mem_q[word_idx] : 32'h0;

  assign instr_gnt_o = instr_req_i & ~gnt_stall_i & (count_q < MaxOut);
  assign push        = instr_req_i & instr_gnt_o;

  assign head_ready     = (count_q != 4'd0) && (wait_q[rptr_q] == 4'd0);
  assign instr_rvalid_o = head_ready & ~rvalid_stall_i;
  assign instr_rdata_o  = instr_rvalid_o ? data_q[rptr_q] : 32'h0;
  assign instr_err_o    = instr_rvalid_o & err_q[rptr_q];
  assign pop            = instr_rvalid_o;

  assign outstanding_o = count_q;
  assign busy_o        = (count_q != 4'd0);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) wptr_d = (wptr_q == PtrLast) ? '0 : wptr_q + PtrW'(1);
    if (pop)  rptr_d = (rptr_q == PtrLast) ? '0 : rptr_q + PtrW'(1);
    if (push && !pop)      count_d = count_q + 4'd1;
    else if (!push && pop) count_d = count_q - 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= 4'd0;
      for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
        data_q[i] <= 32'h0;
        err_q[i]  <= 1'b0;
        wait_q[i] <= 4'd0;
      end
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      // Every entry ages, including ones behind a stalled head.
      for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
        if (wait_q[i] != 4'd0) wait_q[i] <= wait_q[i] - 4'd1;
      end
      if (push) begin
        data_q[wptr_q] <= fetch_data;
        err_q[wptr_q]  <= ~in_range;
        wait_q[wptr_q] <= WaitInit;
      end
    end
  end

  // Array is never reset; a same-cycle fetch reads the pre-write value.
  always_ff @(posedge clk) begin
    if (load_we_i) mem_q[load_addr_i] <= load_wdata_i;
  end

endmodule
